// File: rtl/alu_uart_interface.sv
// rtl/alu_uart_interface.sv - RX byte collector / ALU operand driver / TX result sequencer
// Optional opcode validation and o_op_error port enabled by ALU_IF_OPCODE_CHECK_EN.
module alu_uart_interface #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_dato_a,
    output logic [NB_DATA-1:0] o_dato_b,
    output logic [NB_OP-1:0]   o_operation,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy
`ifdef ALU_IF_OPCODE_CHECK_EN
    ,
    output logic               o_op_error
`endif
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        CALC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    state_t state;
    state_t next_state;

`ifdef ALU_IF_OPCODE_CHECK_EN
    function automatic logic op_supported(input logic [NB_OP-1:0] op);
        return (op == NB_OP'('h20)) || (op == NB_OP'('h22)) ||
               (op == NB_OP'('h24)) || (op == NB_OP'('h25)) ||
               (op == NB_OP'('h26)) || (op == NB_OP'('h03)) ||
               (op == NB_OP'('h02)) || (op == NB_OP'('h27));
    endfunction
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= WAIT_A;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            WAIT_A:  if (i_rx_done) next_state = WAIT_B;
            WAIT_B:  if (i_rx_done) next_state = WAIT_OP;
            WAIT_OP: if (i_rx_done) next_state = CALC;
            CALC:    next_state = SEND;
            SEND:    next_state = WAIT_TX;
            WAIT_TX: if (i_tx_done) next_state = WAIT_A;
            default: next_state = WAIT_A;
        endcase
    end

    // Operand/opcode registers only change on accepted bytes, keeping ALU inputs stable
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_dato_a    <= '0;
            o_dato_b    <= '0;
            o_operation <= '0;
            o_tx_data   <= '0;
`ifdef ALU_IF_OPCODE_CHECK_EN
            o_op_error  <= 1'b0;
`endif
        end else begin
            case (state)
                WAIT_A: begin
                    if (i_rx_done) begin
                        o_dato_a <= i_rx_data;
`ifdef ALU_IF_OPCODE_CHECK_EN
                        o_op_error <= 1'b0;
`endif
                    end
                end
                WAIT_B: begin
                    if (i_rx_done) o_dato_b <= i_rx_data;
                end
                WAIT_OP: begin
                    if (i_rx_done) o_operation <= i_rx_data[NB_OP-1:0];
                end
                CALC: begin
`ifdef ALU_IF_OPCODE_CHECK_EN
                    if (op_supported(o_operation)) begin
                        o_tx_data <= i_alu_result;
                    end else begin
                        o_tx_data  <= '1;
                        o_op_error <= 1'b1;
                    end
`else
                    o_tx_data <= i_alu_result;
`endif
                end
                default: ;
            endcase
        end
    end

    assign o_tx_start = (state == SEND);
    assign o_busy     = (state == CALC) || (state == SEND) || (state == WAIT_TX);

endmodule

// File: tb/tb_alu_uart_interface.sv
// tb/tb_alu_uart_interface.sv - directed and randomized self-checking bench for alu_uart_interface
// Define ALU_IF_OPCODE_CHECK_EN to also exercise the opcode-check build.
module tb_alu_uart_interface;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic [7:0] i_alu_result;
    logic       i_tx_done;
    logic [7:0] o_dato_a;
    logic [7:0] o_dato_b;
    logic [5:0] o_operation;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_busy;
`ifdef ALU_IF_OPCODE_CHECK_EN
    logic       o_op_error;
`endif

    int n_cmp = 0;
    int n_err = 0;

    alu_uart_interface #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_rx_data    (i_rx_data),
        .i_rx_done    (i_rx_done),
        .i_alu_result (i_alu_result),
        .i_tx_done    (i_tx_done),
        .o_dato_a     (o_dato_a),
        .o_dato_b     (o_dato_b),
        .o_operation  (o_operation),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .o_busy       (o_busy)
`ifdef ALU_IF_OPCODE_CHECK_EN
        ,
        .o_op_error   (o_op_error)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Reference ALU: plain arithmetic on the opcode meaning
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h03:   return 8'($signed(a) >>> b);
            6'h02:   return a >> b;
            6'h27:   return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit op_valid(input logic [5:0] op);
        return op inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};
    endfunction

    always_comb i_alu_result = alu_ref(o_dato_a, o_dato_b, o_operation);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
        i_rx_data = 8'($urandom);
    endtask

    // Idle cycles in a WAIT_* state; stray i_tx_done pulses must be ignored
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            i_tx_done = ($urandom_range(0, 2) == 0);
            tick();
            i_tx_done = 1'b0;
            check("idle_busy", o_busy, 0);
        end
    endtask

    task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                       input int gap, input bit junk_in_wait, input bit coincident);
        logic [5:0] op;
        logic [7:0] exp_res;
        bit         bad;
        int         nwait;
        op      = opb[5:0];
        bad     = 1'b0;
        exp_res = alu_ref(a, b, op);
`ifdef ALU_IF_OPCODE_CHECK_EN
        bad = !op_valid(op);
        if (bad) exp_res = 8'hFF;
`endif
        send_byte(a);
        check("dato_a", o_dato_a, a);
        check("busy_after_a", o_busy, 0);
`ifdef ALU_IF_OPCODE_CHECK_EN
        check("op_error_cleared", o_op_error, 0);
`endif
        idle(gap);
        send_byte(b);
        check("dato_b", o_dato_b, b);
        idle(gap);
        send_byte(opb);
        check("operation", o_operation, op);
        check("calc_busy", o_busy, 1);
        check("calc_no_start", o_tx_start, 0);
        tick();
        check("tx_start", o_tx_start, 1);
        check("tx_data", o_tx_data, exp_res);
        check("send_busy", o_busy, 1);
`ifdef ALU_IF_OPCODE_CHECK_EN
        check("op_error", o_op_error, bad);
`endif
        nwait = $urandom_range(1, 4);
        for (int i = 0; i < nwait; i++) begin
            i_rx_done = junk_in_wait;
            i_rx_data = 8'h77;
            tick();
            i_rx_done = 1'b0;
            check("wait_start_low", o_tx_start, 0);
            check("wait_tx_hold", o_tx_data, exp_res);
            check("wait_busy", o_busy, 1);
        end
        i_tx_done = 1'b1;
        i_rx_done = coincident;
        i_rx_data = 8'h77;
        tick();
        i_tx_done = 1'b0;
        i_rx_done = 1'b0;
        check("done_busy", o_busy, 0);
        check("done_dato_a_kept", o_dato_a, a);
        check("done_tx_hold", o_tx_data, exp_res);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed=no_finish expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] ops [8];
        ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};
        i_reset   = 1'b1;
        i_rx_data = 8'h00;
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        tick();
        tick();
        check("rst_dato_a", o_dato_a, 0);
        check("rst_dato_b", o_dato_b, 0);
        check("rst_operation", o_operation, 0);
        check("rst_tx_data", o_tx_data, 0);
        check("rst_tx_start", o_tx_start, 0);
        check("rst_busy", o_busy, 0);
        i_reset = 1'b0;
        tick();

        txn(8'h05, 8'h03, 8'h20, 0, 1'b0, 1'b0);
        check("t1_tx", o_tx_data, 8'h08);
        txn(8'h03, 8'h05, 8'h22, 1, 1'b0, 1'b0);
        check("t2_tx", o_tx_data, 8'hFE);

        send_byte(8'h11);
        send_byte(8'h22);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("t3_rst_a", o_dato_a, 0);
        check("t3_rst_b", o_dato_b, 0);
        check("t3_rst_busy", o_busy, 0);
        txn(8'hF0, 8'h0F, 8'h25, 0, 1'b0, 1'b0);
        check("t3_tx", o_tx_data, 8'hFF);
        check("t3_a", o_dato_a, 8'hF0);

        txn(8'h09, 8'h04, 8'h26, 0, 1'b1, 1'b1);
        txn(8'h01, 8'h02, 8'h24, 0, 1'b0, 1'b0);
        check("t4_tx", o_tx_data, 8'h00);

        idle(3);
        txn(8'h10, 8'h07, 8'hE0, 2, 1'b0, 1'b0);
        check("t5_op", o_operation, 6'h20);
        check("t5_tx", o_tx_data, 8'h17);

`ifdef ALU_IF_OPCODE_CHECK_EN
        txn(8'h05, 8'h03, 8'h3F, 0, 1'b0, 1'b0);
        check("t6_tx", o_tx_data, 8'hFF);
        check("t6_err", o_op_error, 1);
        send_byte(8'h42);
        check("t6_err_clr", o_op_error, 0);
        send_byte(8'h01);
        send_byte(8'h20);
        tick();
        i_tx_done = 1'b1;
        tick();
        tick();
        i_tx_done = 1'b0;
`endif

        for (int t = 0; t < 40; t++) begin
            logic [7:0] opb;
            opb = ops[$urandom_range(0, 7)];
            opb[7:6] = 2'($urandom);
            if ($urandom_range(0, 9) == 0) opb = 8'($urandom);
            txn(8'($urandom), 8'($urandom), opb, $urandom_range(0, 2),
                1'($urandom), 1'($urandom));
            idle($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_uart_interface.md
Name: alu_uart_interface

Overview:
Sequencer that sits between the UART receiver/transmitter and the combinational ALU. It collects three bytes from the RX side (operand A, operand B, opcode) and drives them onto the ALU inputs. It then captures the ALU result and hands it to the UART transmitter with a start/done handshake. It is the operand-producing and result-consuming end of the ALU operand/opcode/result interface.

Parameters:
NB_DATA, 8, width of RX/TX bytes, ALU operands and ALU result
NB_OP, 6, ALU opcode width; taken from opcode byte bits [NB_OP-1:0]

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_reset  input  1  synchronous, active-high reset
i_rx_data  input  NB_DATA  received byte; valid only when i_rx_done=1
i_rx_done  input  1  one-cycle strobe: new byte on i_rx_data
i_alu_result  input  NB_DATA  combinational result returned by the ALU
i_tx_done  input  1  one-cycle strobe: transmitter finished current byte
o_dato_a  output  NB_DATA  registered operand A to ALU
o_dato_b  output  NB_DATA  registered operand B to ALU
o_operation  output  NB_OP  registered opcode to ALU
o_tx_data  output  NB_DATA  byte to transmit; held stable from o_tx_start until i_tx_done
o_tx_start  output  1  one-cycle pulse requesting transmission
o_busy  output  1  high in CALC, SEND and WAIT_TX

Behaviour:
- Reset (sync, i_reset=1 at a clock edge): state<=WAIT_A; o_dato_a, o_dato_b, o_tx_data <= 0; o_operation <= 0; o_tx_start <= 0; o_busy <= 0. Reset overrides every other input in the same cycle, including reset mid-transaction; partially collected operands are discarded.
- FSM states: WAIT_A, WAIT_B, WAIT_OP, CALC, SEND, WAIT_TX.
- WAIT_A: on i_rx_done, o_dato_a<=i_rx_data; go to WAIT_B.
- WAIT_B: on i_rx_done, o_dato_b<=i_rx_data; go to WAIT_OP.
- WAIT_OP: on i_rx_done, o_operation<=i_rx_data[NB_OP-1:0]; go to CALC. Upper byte bits are ignored.
- CALC: one cycle for the ALU to settle on the registered inputs. o_tx_data<=i_alu_result; go to SEND.
- SEND: o_tx_start=1 for exactly this one cycle; go to WAIT_TX.
- WAIT_TX: hold all outputs. On i_tx_done, go to WAIT_A.
- Operand and opcode registers keep their values until overwritten by the next transaction; the ALU inputs stay stable.
- Latency: result is captured 1 cycle after the opcode byte strobe; o_tx_start is asserted 2 cycles after it.
- i_rx_done in CALC, SEND or WAIT_TX: the byte is dropped. This includes i_rx_done coincident with i_tx_done in WAIT_TX; the next transaction starts with the following strobe.
- i_tx_done in any state other than WAIT_TX: ignored.
- i_rx_done held high for several cycles: each high cycle counts as a new byte. The source must supply one-cycle strobes.
- No timeout: the FSM waits indefinitely in WAIT_* states.

Optional Feature:
ALU_IF_OPCODE_CHECK_EN
- Defined: in WAIT_OP the opcode is checked against the supported set {0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x03 sra, 0x02 srl, 0x27 nor}. If valid, behaviour is as above. If invalid, o_operation is still loaded, but CALC loads o_tx_data<=all ones (0xFF for NB_DATA=8) instead of i_alu_result, and an extra output o_op_error (1 bit, reset 0) is set. o_op_error is cleared on the next i_rx_done accepted in WAIT_A.
- Undefined: no check and no o_op_error port; every opcode's ALU result is transmitted.

Test Plan:
1. Reset, then RX strobes 0x05, 0x03, 0x20 with ALU model add -> o_dato_a=0x05, o_dato_b=0x03, o_operation=0x20; o_tx_start pulses once 2 cycles after 3rd strobe with o_tx_data=0x08; after i_tx_done, o_busy=0.
2. RX 0x03, 0x05, 0x22 (sub) -> o_tx_data=0xFE, single o_tx_start pulse; o_tx_data stable until i_tx_done.
3. RX 0x11 then 0x22, assert i_reset one cycle, then RX 0xF0, 0x0F, 0x25 -> partial transaction discarded; o_tx_data=0xFF (or); o_dato_a=0xF0.
4. Complete transaction; while in WAIT_TX send RX 0x77, including one strobe coincident with i_tx_done -> byte dropped; next strobes 0x01, 0x02, 0x24 give o_dato_a=0x01 and o_tx_data=0x00.
5. i_tx_done pulsed in WAIT_A/WAIT_B -> no state change; opcode byte 0xE0 -> o_operation=0x20.
6. With ALU_IF_OPCODE_CHECK_EN: RX 0x05, 0x03, 0x3F -> o_tx_data=0xFF, o_op_error=1; next accepted byte clears o_op_error to 0.
